// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-queue entry layout, NOP encoding and fetch FSM states.
package cpu_pkg;

    localparam logic [31:0] NOP        = 32'hE1A0_0000;  // MOV R0,R0
    localparam int          WORD_BYTES = 4;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // 65-bit queue entry {fault, pc, instr}
    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of fetch entries; flush beats push and pop.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // Push into a full queue is legal only when the head leaves the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the head never reads X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives memory address, queues returned words, flags faulting fetches.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 800
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_BYTES - 3);

    logic [31:0]          r_pc;
    logic [0:0]           r_state;
    logic                 w_fault;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic [$clog2(DEPTH):0] w_count;
    fetch_entry_t         w_entry;
    fetch_entry_t         w_head;

    assign mem_address = r_pc;
    assign w_fault     = (r_pc[1:0] != 2'b00) || (r_pc >= PC_LIMIT);

    // Faulting addresses get a NOP; memory returns garbage out there.
    assign w_entry.fault = w_fault;
    assign w_entry.pc    = r_pc;
    assign w_entry.instr = w_fault ? NOP : mem_read_data;

    assign w_pop  = !w_empty && instr_ready;
    assign w_push = (r_state == ST_RUN) && !redirect_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_state <= ST_RUN;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= ST_RUN;
        end else if (w_push) begin
            if (w_fault) r_state <= ST_HALT;
            else         r_pc    <= r_pc + 32'(WORD_BYTES);
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign instr_valid = (w_count != '0);
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;
    assign instr_fault = w_head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every cycle plus directed literal checks.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int MEM_BYTES = 800;
    localparam int DEPTH     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_address;
    logic [31:0] mem_read_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 0;

    logic [7:0] mem [MEM_BYTES];

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_read_data  (mem_read_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault)
    );

    always #5 clk = ~clk;

    // Little-endian word read; beyond the array the memory returns junk.
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a < 32'(MEM_BYTES - 3))
            return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        return 32'hDEAD_BEEF;
    endfunction

    assign mem_read_data = memword(mem_address);

    task automatic putword(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of expected entries and the next fetch address.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    bit          mhalt;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                mpc    = 32'h0;
                mhalt  = 0;
                chk_en = 1;
            end else if (redirect_valid) begin
                mq.delete();
                mpc   = redirect_pc;
                mhalt = 0;
            end else begin
                bit   pop;
                bit   push;
                ent_t e;
                pop  = (mq.size() != 0) && instr_ready;
                push = !mhalt && ((mq.size() < DEPTH) || pop);
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.pc = mpc;
                    if (mpc % 4 == 0 && mpc < MEM_BYTES - 3) begin
                        e.instr = memword(mpc);
                        e.fault = 0;
                        mpc     = mpc + 4;
                    end else begin
                        e.instr = 32'hE1A0_0000;
                        e.fault = 1;
                        mhalt   = 1;
                    end
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
            check("model mem_address", mem_address, mpc);
            if (mq.size() != 0) begin
                check("model instr", instr, mq[0].instr);
                check("model instr_pc", instr_pc, mq[0].pc);
                check("model fault", {31'b0, instr_fault}, {31'b0, mq[0].fault});
            end
        end
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        for (int a = 0; a < MEM_BYTES; a += 4) putword(a, 32'hE1A0_0000);
        putword(32'h00, 32'hE3A0_0005);
        putword(32'h04, 32'hE3A0_100F);
        putword(32'h08, 32'hE080_0001);
        putword(32'h0C, 32'hE040_0001);
        putword(32'h10, 32'hE150_0001);
        putword(32'h14, 32'hEAFF_FFFE);

        // reset state, then in-order stream
        @(negedge clk);
        check("rst valid", {31'b0, instr_valid}, 32'h0);
        check("rst instr", instr, 32'h0);
        check("rst pc", instr_pc, 32'h0);
        check("rst fault", {31'b0, instr_fault}, 32'h0);
        check("rst mem_address", mem_address, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("s1 instr", instr, 32'hE3A0_0005);
        check("s1 pc", instr_pc, 32'h0);
        @(negedge clk);
        check("s2 instr", instr, 32'hE3A0_100F);
        check("s2 pc", instr_pc, 32'h4);
        @(negedge clk);
        check("s3 instr", instr, 32'hE080_0001);
        check("s3 pc", instr_pc, 32'h8);
        repeat (4) @(negedge clk);
        check("s7 instr", instr, 32'hE1A0_0000);
        check("s7 pc", instr_pc, 32'h18);

        // backpressure fills the queue, then drains with no gap
        reset = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("bp mem_address", mem_address, 32'h10);
        check("bp pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("drain valid", {31'b0, instr_valid}, 32'h1);
            check("drain pc", instr_pc, 32'(4 * i));
        end

        // redirect with a full queue and a concurrent pop
        instr_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("full valid", {31'b0, instr_valid}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h8; instr_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("rd8 gap", {31'b0, instr_valid}, 32'h0);
        @(negedge clk);
        check("rd8 instr", instr, 32'hE080_0001);
        check("rd8 pc", instr_pc, 32'h8);

        // run off the end of memory
        redirect_valid = 1'b1; redirect_pc = 32'h31C;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("end gap", {31'b0, instr_valid}, 32'h0);
        @(negedge clk);
        check("end pc0", instr_pc, 32'h31C);
        check("end instr0", instr, 32'hE1A0_0000);
        check("end fault0", {31'b0, instr_fault}, 32'h0);
        @(negedge clk);
        check("end pc1", instr_pc, 32'h320);
        check("end fault1", {31'b0, instr_fault}, 32'h1);
        check("end instr1", instr, 32'hE1A0_0000);
        repeat (4) @(negedge clk);
        check("halt valid", {31'b0, instr_valid}, 32'h0);
        check("halt mem_address", mem_address, 32'h320);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("resume instr", instr, 32'hE3A0_0005);

        // misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("mis pc", instr_pc, 32'h6);
        check("mis fault", {31'b0, instr_fault}, 32'h1);
        check("mis instr", instr, 32'hE1A0_0000);
        @(negedge clk);
        check("mis halt valid", {31'b0, instr_valid}, 32'h0);
        check("mis mem_address", mem_address, 32'h6);

        // reset mid-stream discards queued entries
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("mid valid", {31'b0, instr_valid}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("mid rst valid", {31'b0, instr_valid}, 32'h0);
        reset = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        check("mid first pc", instr_pc, 32'h0);
        check("mid first instr", instr, 32'hE3A0_0005);

        // irregular ready pattern, model-checked only
        for (int i = 0; i < 60; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the byte-addressed, little-endian-assembled unified memory. It drives the memory's combinational read address and captures the returned 32-bit word each cycle. Captured words are buffered in a small prefetch queue and handed to decode over a valid/ready handshake. It supports branch redirect with queue flush, and flags fetches from misaligned or out-of-range addresses as faults.

Parameters:
DEPTH, 4, prefetch queue entries; power of 2, minimum 2
RESET_PC, 32'h0000_0000, fetch address after reset
MEM_BYTES, 800, memory size in bytes; a fetch is legal only when the address is below MEM_BYTES-3

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  reset, synchronous, active-high
mem_address  output  32  read address to memory; combinational copy of fetch_pc
mem_read_data  input  32  word returned combinationally by memory for mem_address
redirect_valid  input  1  branch/exception redirect request, single-cycle pulse
redirect_pc  input  32  new fetch address, sampled when redirect_valid=1
instr_valid  output  1  queue head holds an entry
instr_ready  input  1  decode accepts the head this cycle
instr  output  32  head instruction word
instr_pc  output  32  byte address of the head instruction
instr_fault  output  1  head entry is a fetch fault; instr reads NOP in that case

Behaviour:
- Reset (at posedge with reset=1): fetch_pc=RESET_PC, state=RUN, queue count=0, read/write pointers=0. Outputs: instr_valid=0, instr=0, instr_pc=0, instr_fault=0. Reset has priority over every other input and discards any in-flight entries.
- States:
  - RUN: fetching sequentially.
  - HALT: fault entry already queued; no pushes; mem_address holds the faulting pc.
- Transitions:
  - RUN->HALT when a fault entry is pushed.
  - HALT->RUN on redirect.
- Push condition, evaluated each cycle: state=RUN, no redirect, and (count<DEPTH or (instr_valid and instr_ready)).
- On push, in RUN with fetch_pc[1:0]=0 and fetch_pc<MEM_BYTES-3:
  - Enqueue {mem_read_data, fetch_pc, fault=0}.
  - fetch_pc+=4, 32-bit modulo.
- On push, when fetch_pc is misaligned or fetch_pc>=MEM_BYTES-3:
  - Enqueue {NOP, fetch_pc, fault=1}.
  - fetch_pc unchanged; go to HALT.
  - Memory data is ignored, since memory drives z in this range.
- Pop occurs when instr_valid and instr_ready; the head advances at the posedge.
- Simultaneous push and pop when full is allowed; count stays at DEPTH.
- Redirect (redirect_valid=1 at posedge, reset=0):
  - Flush the queue: count=0, pointers reset.
  - fetch_pc=redirect_pc; state=RUN; no push that cycle.
  - A pop in the same cycle is discarded; redirect wins.
  - Next cycle instr_valid=0; the first redirected entry is visible the cycle after.
- Latency:
  - One cycle from fetch_pc presented on mem_address to the entry appearing at the head when the queue is empty.
  - First instruction is valid on the 1st posedge after reset deasserts.
- instr, instr_pc and instr_fault reflect the head entry whenever instr_valid=1. Their values when instr_valid=0 are don't-care for consumers but must not be X after reset.
- instr_valid = (count!=0); there are no combinational paths from instr_ready to instr_valid.
- Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.
- Throughput: one instruction per cycle sustained when instr_ready=1.

Decomposition:
- Shared package cpu_pkg:
  - NOP constant 32'hE1A0_0000 (MOV R0,R0).
  - WORD_BYTES=4.
  - Fetch state encoding {RUN, HALT}.
- One sub-module, fetch_queue: synchronous FIFO, DEPTH x 65 bits {fault, pc, instr}.
  - Inputs: push, pop, flush. Outputs: head, count, empty, full.
  - flush has priority over push and pop.

Test Plan:
- Reset with the memory's program image loaded, instr_ready=1 -> instructions emitted in order, one per cycle:
  - cycle 1: instr=E3A00005, pc=0
  - cycle 2: E3A0100F, pc=4
  - cycle 3: E0800001, pc=8
  - after pc=0x14: NOP E1A00000
- instr_ready=0 for 6 cycles after reset -> count saturates at 4, mem_address holds 0x10. Raise ready -> pcs 0,4,8,C,10 are delivered back-to-back with no gap or duplicate.
- Queue full, redirect_valid=1 with redirect_pc=0x8 and instr_ready=1 in the same cycle -> next cycle instr_valid=0; the following cycle instr=E0800001 with instr_pc=8.
- Redirect to 0x31C with MEM_BYTES=800:
  - Entries: pc 0x31C NOP fault=0, then pc 0x320 fault=1.
  - No further pushes; mem_address stays 0x320.
  - Redirect to 0x0 then resumes at E3A00005.
- Redirect to 0x6 -> single entry pc=6, fault=1, instr=E1A00000; state HALT.
- Reset asserted mid-stream with 3 entries queued and ready=0 -> next cycle instr_valid=0. After deassert, the first instruction is pc=0 (RESET_PC).
